// File: rtl/reg4_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg4_arb_pkg
// Shared definitions for the round-robin shared-register write arbiter.
//   state_e  : FSM state encoding (ST_IDLE / ST_OWN)
//   MAX_REQ  : widest requester vector the pick function handles
//   rr_pick  : round-robin search, returns {found, idx}
// -----------------------------------------------------------------------------
package reg4_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    localparam int MAX_REQ = 8;

    // Scan from ptr upward, wrapping modulo 8. Callers zero-extend their
    // N_REQ-bit request vector and keep ptr < N_REQ. The padding bits are
    // always zero, so the wrap order equals the modulo-N_REQ order.
    // When excl_en is set, requester excl_idx is never selected.
    function automatic logic [3:0] rr_pick(
        input logic [7:0] req_vec,
        input logic [2:0] ptr,
        input logic       excl_en,
        input logic [2:0] excl_idx
    );
        logic [7:0] cand;
        logic       found;
        logic [2:0] idx;
        logic [2:0] k;
        cand = req_vec;
        if (excl_en) begin
            cand[excl_idx] = 1'b0;
        end else begin
            cand = req_vec;
        end
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k     = ptr + i[2:0];
            idx   = (!found && cand[k]) ? k : idx;
            found = found | cand[k];
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/reg4_store.sv
// -----------------------------------------------------------------------------
// reg4_store
// The W-bit shared storage register written by the arbiter on commit edges.
//   clk  : rising-edge clock
//   r    : asynchronous active-high clear
//   we_i : write enable (high on a commit edge)
//   d_i  : data to store
//   q_o  : stored value
// -----------------------------------------------------------------------------
module reg4_store #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Storage register: clears on reset, loads only when a commit is signalled.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            data_q <= {W{1'b0}};
        end else if (we_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// reg4_rr_arbiter
// Round-robin write arbiter sharing one W-bit register among N_REQ requesters.
// One owner holds the grant at a time. Each edge where the owner still
// requests commits its data and produces a one-cycle ack. lock lets the owner
// keep the grant for up to MAX_LOCK commits in one tenure.
//   clk   : rising-edge clock
//   r     : asynchronous active-high reset
//   req   : per-requester write request (level)
//   lock  : per-requester hold request (only the owner's bit matters)
//   wdata : packed write data, requester i at [i*W +: W]
//   gnt   : one-hot grant (registered)
//   ack   : one-cycle commit pulse (registered)
//   q     : shared register contents
//   owner : index of current / last owner
//   busy  : high while a tenure is active
// -----------------------------------------------------------------------------
import reg4_arb_pkg::*;

module reg4_rr_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int W        = 4,
    parameter  int MAX_LOCK = 4,
    localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               r,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   lock,
    input  logic [N_REQ*W-1:0] wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       q,
    output logic [OW-1:0]      owner,
    output logic               busy
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]    lock_cnt_inc_s;

    logic [7:0]       req_ext_s;
    logic [2:0]       ptr_ext_s;
    logic [2:0]       owner_ext_s;
    logic [3:0]       pick_idle_s;
    logic [3:0]       pick_hand_s;
    logic [OW-1:0]    idle_idx_s;
    logic [OW-1:0]    hand_idx_s;
    logic             tenure_end_s;
    logic             we_s;
    logic [W-1:0]     wdata_sel_s;

    assign req_ext_s   = 8'(req);
    assign ptr_ext_s   = 3'(ptr_q);
    assign owner_ext_s = 3'(owner_q);
    assign pick_idle_s = rr_pick(req_ext_s, ptr_ext_s, 1'b0, 3'd0);
    // The outgoing owner is excluded so it cannot be regranted on the edge
    // its tenure ends; it must pass through IDLE first.
    assign pick_hand_s = rr_pick(req_ext_s, ptr_ext_s, 1'b1, owner_ext_s);
    assign idle_idx_s  = OW'(pick_idle_s[2:0]);
    assign hand_idx_s  = OW'(pick_hand_s[2:0]);
    assign wdata_sel_s = wdata[owner_q*W +: W];

    // Next-state logic: grant selection, commit/abort, lock bound and handoff.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        ack_d          = {N_REQ{1'b0}};
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        lock_cnt_d     = lock_cnt_q;
        we_s           = 1'b0;
        tenure_end_s   = 1'b0;
        lock_cnt_inc_s = lock_cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (pick_idle_s[3]) begin
                    state_d             = ST_OWN;
                    gnt_d               = {N_REQ{1'b0}};
                    gnt_d[idle_idx_s]   = 1'b1;
                    owner_d             = idle_idx_s;
                    ptr_d               = (idle_idx_s == OW'(N_REQ - 1)) ? {OW{1'b0}}
                                                                         : idle_idx_s + OW'(1);
                    lock_cnt_d          = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = {N_REQ{1'b0}};
                end
            end
            ST_OWN: begin
                if (req[owner_q]) begin
                    we_s           = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    lock_cnt_d     = lock_cnt_inc_s;
                    tenure_end_s   = !(lock[owner_q] && (lock_cnt_inc_s < CW'(MAX_LOCK)));
                end else begin
                    // Owner dropped its request: abort without writing.
                    tenure_end_s = 1'b1;
                end
                if (tenure_end_s) begin
                    if (pick_hand_s[3]) begin
                        state_d           = ST_OWN;
                        gnt_d             = {N_REQ{1'b0}};
                        gnt_d[hand_idx_s] = 1'b1;
                        owner_d           = hand_idx_s;
                        ptr_d             = (hand_idx_s == OW'(N_REQ - 1)) ? {OW{1'b0}}
                                                                           : hand_idx_s + OW'(1);
                        lock_cnt_d        = {CW{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = {N_REQ{1'b0}};
                    end
                end else begin
                    state_d = ST_OWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {N_REQ{1'b0}};
            end
        endcase
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q    <= ST_IDLE;
            gnt_q      <= {N_REQ{1'b0}};
            ack_q      <= {N_REQ{1'b0}};
            owner_q    <= {OW{1'b0}};
            ptr_q      <= {OW{1'b0}};
            lock_cnt_q <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    reg4_store #(
        .W (W)
    ) u_store (
        .clk  (clk),
        .r    (r),
        .we_i (we_s),
        .d_i  (wdata_sel_s),
        .q_o  (q)
    );

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign busy  = (state_q == ST_OWN);

endmodule

// File: tb/tb_reg4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg4_rr_arbiter
// Self-checking bench for reg4_rr_arbiter: a behavioural model checked every
// cycle plus directed scenarios with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_reg4_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int ML = 4;

    logic           clk = 1'b0;
    logic           r;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [N-1:0] m_gnt   = '0;
    logic [N-1:0] m_ack   = '0;
    logic [W-1:0] m_q     = '0;
    logic         m_busy  = 1'b0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    int           m_cnt   = 0;

    reg4_rr_arbiter #(.N_REQ(N), .W(W), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .r     (r),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requester at or after ptr (wrapping), skipping excl; -1 if none.
    function automatic int pick(input logic [N-1:0] rv, input int ptr, input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (idx != excl && rv[idx]) return idx;
        end
        return -1;
    endfunction

    // Behavioural model of the arbiter rules.
    always @(posedge clk or posedge r) begin : model
        int           o, w, c, nptr, nown;
        logic [N-1:0] ng, na;
        logic [W-1:0] nq;
        logic         nb, ended;
        ng = m_gnt; na = '0; nq = m_q; nb = m_busy;
        c = m_cnt; nptr = m_ptr; nown = m_owner; w = -1;
        if (r) begin
            ng = '0; nq = '0; nb = 1'b0; c = 0; nptr = 0; nown = 0;
        end else if (!m_busy) begin
            w = pick(req, m_ptr, -1);
            if (w < 0) ng = '0;
        end else begin
            o = m_owner;
            ended = 1'b1;
            if (req[o]) begin
                nq    = wdata[o*W +: W];
                na[o] = 1'b1;
                c     = m_cnt + 1;
                ended = !(lock[o] && (c < ML));
            end
            if (ended) begin
                w = pick(req, m_ptr, o);
                if (w < 0) begin
                    nb = 1'b0;
                    ng = '0;
                end
            end
        end
        if (!r && w >= 0) begin
            ng = '0; ng[w] = 1'b1; nown = w; nptr = (w + 1) % N; c = 0; nb = 1'b1;
        end
        m_gnt   <= ng;
        m_ack   <= na;
        m_q     <= nq;
        m_busy  <= nb;
        m_owner <= nown;
        m_ptr   <= nptr;
        m_cnt   <= c;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("m_gnt",   gnt,   m_gnt);
        check("m_ack",   ack,   m_ack);
        check("m_q",     q,     m_q);
        check("m_owner", owner, m_owner[1:0]);
        check("m_busy",  busy,  m_busy);
        check("onehot",  $onehot0(gnt), 1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        r = 1'b1;
        #4;
        r = 1'b0;
    endtask

    initial begin
        logic [3:0] q_exp [5];
        logic [3:0] a_exp [5];
        logic [3:0] g_exp [5];
        q_exp = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd8};
        a_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        g_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        r = 1'b1; req = '0; lock = '0; wdata = '0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);

        // 1. single commit
        step(1);
        r = 1'b0; req = 4'b0001; wdata = 16'h0005;
        step(1);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        step(1);
        check("t1_q", q, 5);
        check("t1_ack", ack, 4'b0001);
        check("t1_gnt_idle", gnt, 0);
        check("t1_busy_idle", busy, 0);
        req = 4'b0000;
        step(1);
        check("t1_ack_once", ack, 0);
        check("t1_q_hold", q, 5);

        // 2. round-robin fairness
        do_reset();
        req = 4'b1111; lock = 4'b0000; wdata = 16'hBA98;
        step(1);
        check("t2_gnt0", gnt, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("t2_q", q, q_exp[k]);
            check("t2_ack", ack, a_exp[k]);
            check("t2_gnt", gnt, g_exp[k]);
            check("t2_busy", busy, 1);
        end
        req = 4'b0000;

        // 3. lock bound with a waiting requester
        do_reset();
        req = 4'b0011; lock = 4'b0001; wdata = 16'h0063;
        step(1);
        check("t3_gnt0", gnt, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t3_ack", ack, 4'b0001);
            check("t3_q", q, 3);
            check("t3_gnt", gnt, (k < 3) ? 4'b0001 : 4'b0010);
        end
        step(1);
        check("t3_ack1", ack, 4'b0010);
        check("t3_q1", q, 6);
        check("t3_gnt_back", gnt, 4'b0001);
        req = 4'b0000; lock = 4'b0000;

        // 4. lone locked requester
        do_reset();
        req = 4'b0001; lock = 4'b0001; wdata = 16'h0009;
        step(1);
        check("t4_gnt0", gnt, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t4_ack", ack, 4'b0001);
            check("t4_q", q, 9);
            check("t4_gnt", gnt, (k < 3) ? 4'b0001 : 4'b0000);
        end
        check("t4_idle", busy, 0);
        step(1);
        check("t4_regrant", gnt, 4'b0001);
        check("t4_noack", ack, 0);
        check("t4_busy", busy, 1);
        req = 4'b0000; lock = 4'b0000;

        // 5. abort
        do_reset();
        req = 4'b0100; wdata = 16'h0700;
        step(1);
        check("t5_gnt2", gnt, 4'b0100);
        check("t5_own2", owner, 2);
        req = 4'b0001;
        step(1);
        check("t5_noack", ack, 0);
        check("t5_q", q, 0);
        check("t5_hand", gnt, 4'b0001);
        check("t5_own0", owner, 0);
        req = 4'b0000;
        step(1);
        check("t5_idle_gnt", gnt, 0);
        check("t5_idle_busy", busy, 0);
        check("t5_noack2", ack, 0);
        check("t5_q2", q, 0);

        // 6. asynchronous reset mid-tenure
        do_reset();
        req = 4'b0100; lock = 4'b0100; wdata = 16'h0700;
        step(1);
        check("t6_gnt", gnt, 4'b0100);
        step(1);
        check("t6_q7", q, 7);
        check("t6_gnt_hold", gnt, 4'b0100);
        r = 1'b1;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_ack", ack, 0);
        check("t6_rst_q", q, 0);
        check("t6_rst_busy", busy, 0);
        #3;
        r = 1'b0; req = 4'b1111; lock = 4'b0000; wdata = 16'h4321;
        step(1);
        check("t6_first", gnt, 4'b0001);
        check("t6_owner", owner, 0);
        step(1);
        check("t6_q1", q, 1);
        check("t6_ack0", ack, 4'b0001);
        check("t6_next", gnt, 4'b0010);
        req = 4'b0000;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
